// File: rtl/multi_cycle_writeback_queue.sv
// Writeback queue for multicycle execute results. Results leaving stage 5 are
// held in a FIFO until the shared register-file writeback port is free; the
// single-cycle pipeline always wins that port. Issue credits bound the number
// of results in flight, and an age counter on the head raises a starvation
// hold so the scheduler can open a gap in single-cycle traffic.
module multi_cycle_writeback_queue #(
    parameter int unsigned VECTOR_LANES     = 16,
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned STARVE_LIMIT     = 4,
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned THREAD_IDX_WIDTH = 2,
    parameter int unsigned SUBCYCLE_WIDTH   = 2,
    parameter int unsigned LANE_WIDTH       = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mx_issue,
    input  logic                                 mx5_instruction_valid,
    input  logic [INSTR_WIDTH-1:0]               mx5_instruction,
    input  logic [VECTOR_LANES-1:0]              mx5_mask_value,
    input  logic [THREAD_IDX_WIDTH-1:0]          mx5_thread_idx,
    input  logic [SUBCYCLE_WIDTH-1:0]            mx5_subcycle,
    input  logic [VECTOR_LANES*LANE_WIDTH-1:0]   mx5_result,
    input  logic                                 sc_wb_request,
    output logic                                 mq_wb_valid,
    output logic [INSTR_WIDTH-1:0]               mq_wb_instruction,
    output logic [VECTOR_LANES-1:0]              mq_wb_mask_value,
    output logic [THREAD_IDX_WIDTH-1:0]          mq_wb_thread_idx,
    output logic [SUBCYCLE_WIDTH-1:0]            mq_wb_subcycle,
    output logic [VECTOR_LANES*LANE_WIDTH-1:0]   mq_wb_result,
    output logic                                 mq_credit_stall,
    output logic                                 mq_starve_hold,
    output logic [$clog2(DEPTH):0]               mq_occupancy
);

    localparam int unsigned RESULT_W = VECTOR_LANES * LANE_WIDTH;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned ENTRY_W  = INSTR_WIDTH + VECTOR_LANES + THREAD_IDX_WIDTH
                                     + SUBCYCLE_WIDTH + RESULT_W;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] STARVE_AGE = AGE_W'(STARVE_LIMIT);

    logic [ENTRY_W-1:0] fifo_mem [DEPTH];

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic               wb_valid_q, wb_valid_d;
    logic [ENTRY_W-1:0] wb_payload_q, wb_payload_d;

    logic [ENTRY_W-1:0] mx5_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               queue_empty;
    logic               push;
    logic               pop;
    logic               bypass;
    logic               deliver;

    assign mx5_entry   = {mx5_instruction, mx5_mask_value, mx5_thread_idx,
                          mx5_subcycle, mx5_result};
    assign head_entry  = fifo_mem[rd_ptr_q];
    assign queue_empty = (count_q == '0);

    // Delivery decision: single-cycle request first, then queue head, then bypass.
    always_comb begin
        pop     = 1'b0;
        bypass  = 1'b0;
        push    = 1'b0;
        if (sc_wb_request) begin
            push = mx5_instruction_valid;
        end else if (!queue_empty) begin
            pop  = 1'b1;
            push = mx5_instruction_valid;
        end else begin
            bypass = mx5_instruction_valid;
        end
        deliver = pop | bypass;
    end

    // Next-state for pointers, count, credits, age and the writeback register.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        credits_d    = credits_q;
        age_d        = age_q;
        wb_valid_d   = deliver;
        wb_payload_d = wb_payload_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // An issue without a delivery saturates at DEPTH; that only happens
        // when the scheduler ignores the stall.
        if (mx_issue && !deliver && (credits_q != DEPTH_CNT)) begin
            credits_d = credits_q + CNT_W'(1);
        end else if (deliver && !mx_issue && (credits_q != '0)) begin
            credits_d = credits_q - CNT_W'(1);
        end

        if (pop || queue_empty) begin
            age_d = '0;
        end else if (age_q != STARVE_AGE) begin
            age_d = age_q + AGE_W'(1);
        end

        if (pop) begin
            wb_payload_d = head_entry;
        end else if (bypass) begin
            wb_payload_d = mx5_entry;
        end
    end

    // Control and output registers; all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            credits_q    <= '0;
            age_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_payload_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            credits_q    <= credits_d;
            age_q        <= age_d;
            wb_valid_q   <= wb_valid_d;
            wb_payload_q <= wb_payload_d;
        end
    end

    // Queue storage; contents are meaningless outside [rd_ptr, wr_ptr) so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mx5_entry;
        end
    end

    assign mq_wb_valid = wb_valid_q;
    assign {mq_wb_instruction, mq_wb_mask_value, mq_wb_thread_idx,
            mq_wb_subcycle, mq_wb_result} = wb_payload_q;
    assign mq_credit_stall = (credits_q == DEPTH_CNT);
    assign mq_starve_hold  = (age_q == STARVE_AGE);
    assign mq_occupancy    = count_q;

endmodule

// File: tb/tb_multi_cycle_writeback_queue.sv
// Directed bench for multi_cycle_writeback_queue: bypass, blocking with
// starvation hold, credit exhaustion, simultaneous push/pop across pointer
// wrap, and asynchronous reset in the middle of traffic.
module tb_multi_cycle_writeback_queue;

    logic         clk;
    logic         reset;
    logic         mx_issue;
    logic         mx5_instruction_valid;
    logic [31:0]  mx5_instruction;
    logic [15:0]  mx5_mask_value;
    logic [1:0]   mx5_thread_idx;
    logic [1:0]   mx5_subcycle;
    logic [511:0] mx5_result;
    logic         sc_wb_request;
    logic         mq_wb_valid;
    logic [31:0]  mq_wb_instruction;
    logic [15:0]  mq_wb_mask_value;
    logic [1:0]   mq_wb_thread_idx;
    logic [1:0]   mq_wb_subcycle;
    logic [511:0] mq_wb_result;
    logic         mq_credit_stall;
    logic         mq_starve_hold;
    logic [3:0]   mq_occupancy;

    int errors = 0;
    int checks = 0;

    multi_cycle_writeback_queue dut (
        .clk                   (clk),
        .reset                 (reset),
        .mx_issue              (mx_issue),
        .mx5_instruction_valid (mx5_instruction_valid),
        .mx5_instruction       (mx5_instruction),
        .mx5_mask_value        (mx5_mask_value),
        .mx5_thread_idx        (mx5_thread_idx),
        .mx5_subcycle          (mx5_subcycle),
        .mx5_result            (mx5_result),
        .sc_wb_request         (sc_wb_request),
        .mq_wb_valid           (mq_wb_valid),
        .mq_wb_instruction     (mq_wb_instruction),
        .mq_wb_mask_value      (mq_wb_mask_value),
        .mq_wb_thread_idx      (mq_wb_thread_idx),
        .mq_wb_subcycle        (mq_wb_subcycle),
        .mq_wb_result          (mq_wb_result),
        .mq_credit_stall       (mq_credit_stall),
        .mq_starve_hold        (mq_starve_hold),
        .mq_occupancy          (mq_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mx(input logic v, input logic [31:0] tag);
        mx5_instruction_valid = v;
        mx5_instruction       = tag;
        mx5_mask_value        = tag[15:0] ^ 16'hffff;
        mx5_thread_idx        = tag[1:0];
        mx5_subcycle          = tag[3:2];
        mx5_result            = {16{tag}};
    endtask

    initial begin
        reset         = 1'b1;
        mx_issue      = 1'b0;
        sc_wb_request = 1'b0;
        set_mx(1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", mq_wb_valid, 0);
        chk("rst_stall", mq_credit_stall, 0);
        chk("rst_hold", mq_starve_hold, 0);
        chk("rst_occ", mq_occupancy, 0);
        chk("rst_instr", mq_wb_instruction, 0);
        tick();
        tick();
        reset = 1'b1;

        // Bypass: one issue, result five cycles later, delivered next cycle.
        mx_issue = 1'b1;
        tick();
        mx_issue = 1'b0;
        chk("byp_credits1", dut.credits_q, 1);
        repeat (4) tick();
        set_mx(1'b1, 32'h3f800000);
        chk("byp_pre_valid", mq_wb_valid, 0);
        tick();
        set_mx(1'b0, 32'h0);
        chk("byp_valid", mq_wb_valid, 1);
        chk("byp_lane0", mq_wb_result[31:0], 64'h3f800000);
        chk("byp_mask", mq_wb_mask_value, 16'hffff ^ 16'h0000);
        chk("byp_occ", mq_occupancy, 0);
        chk("byp_credits0", dut.credits_q, 0);
        tick();
        chk("byp_valid_drop", mq_wb_valid, 0);

        // Blocking: three results queued behind a single-cycle request.
        mx_issue = 1'b1;
        repeat (3) tick();
        mx_issue = 1'b0;
        sc_wb_request = 1'b1;
        set_mx(1'b1, 32'h0000000a);
        tick();
        chk("blk_occ1", mq_occupancy, 1);
        chk("blk_valid", mq_wb_valid, 0);
        set_mx(1'b1, 32'h0000000b);
        tick();
        set_mx(1'b1, 32'h0000000c);
        tick();
        set_mx(1'b0, 32'h0);
        chk("blk_occ3", mq_occupancy, 3);
        chk("blk_hold_early", mq_starve_hold, 0);
        tick();
        chk("blk_hold_age3", mq_starve_hold, 0);
        tick();
        chk("blk_hold_rise", mq_starve_hold, 1);
        tick();
        chk("blk_hold_sat", mq_starve_hold, 1);
        chk("blk_still_idle", mq_wb_valid, 0);
        sc_wb_request = 1'b0;
        tick();
        chk("blk_a_valid", mq_wb_valid, 1);
        chk("blk_a_tag", mq_wb_instruction, 32'h0a);
        chk("blk_hold_fall", mq_starve_hold, 0);
        chk("blk_occ2", mq_occupancy, 2);
        tick();
        chk("blk_b_tag", mq_wb_instruction, 32'h0b);
        chk("blk_b_thread", mq_wb_thread_idx, 2'b11);
        tick();
        chk("blk_c_tag", mq_wb_instruction, 32'h0c);
        chk("blk_c_lane15", mq_wb_result[511:480], 64'h0c);
        chk("blk_occ0", mq_occupancy, 0);
        tick();
        chk("blk_done_valid", mq_wb_valid, 0);
        chk("blk_credits", dut.credits_q, 0);

        // Credit exhaustion.
        mx_issue = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("cr_stall_ramp", mq_credit_stall, (i == 7) ? 1 : 0);
        end
        // Issue while stalled: illegal, credits must saturate rather than wrap.
        tick();
        chk("cr_sat_stall", mq_credit_stall, 1);
        chk("cr_sat_count", dut.credits_q, 8);
        set_mx(1'b1, 32'h00000200);
        tick();
        chk("cr_deliv_issue_valid", mq_wb_valid, 1);
        chk("cr_deliv_issue_stall", mq_credit_stall, 1);
        mx_issue = 1'b0;
        set_mx(1'b1, 32'h00000201);
        tick();
        chk("cr_deliv_clear", mq_credit_stall, 0);
        chk("cr_deliv_count", dut.credits_q, 7);
        for (int i = 0; i < 7; i++) begin
            set_mx(1'b1, 32'(32'h210 + i));
            tick();
        end
        set_mx(1'b0, 32'h0);
        chk("cr_drained", dut.credits_q, 0);
        tick();

        // Push and pop together with two entries queued, across pointer wrap.
        mx_issue = 1'b1;
        sc_wb_request = 1'b1;
        set_mx(1'b1, 32'h00000100);
        tick();
        set_mx(1'b1, 32'h00000101);
        tick();
        sc_wb_request = 1'b0;
        chk("pp_occ_start", mq_occupancy, 2);
        for (int i = 0; i < 20; i++) begin
            set_mx(1'b1, 32'(32'h102 + i));
            tick();
            chk("pp_valid", mq_wb_valid, 1);
            chk("pp_tag", mq_wb_instruction, 32'(32'h100 + i));
            chk("pp_occ", mq_occupancy, 2);
        end
        mx_issue = 1'b0;
        set_mx(1'b0, 32'h0);
        tick();
        chk("pp_tail0", mq_wb_instruction, 32'h114);
        tick();
        chk("pp_tail1", mq_wb_instruction, 32'h115);
        chk("pp_tail1_sub", mq_wb_subcycle, 2'b01);
        chk("pp_empty", mq_occupancy, 0);
        tick();
        chk("pp_credits", dut.credits_q, 0);

        // Reset mid-operation with five queued and seven credits outstanding.
        mx_issue = 1'b1;
        repeat (7) tick();
        mx_issue = 1'b0;
        sc_wb_request = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_mx(1'b1, 32'(32'h300 + i));
            tick();
        end
        set_mx(1'b0, 32'h0);
        chk("mr_occ5", mq_occupancy, 5);
        chk("mr_credits7", dut.credits_q, 7);
        chk("mr_hold_pre", mq_starve_hold, 1);
        #2 reset = 1'b0;
        #1;
        chk("mr_valid", mq_wb_valid, 0);
        chk("mr_occ", mq_occupancy, 0);
        chk("mr_stall", mq_credit_stall, 0);
        chk("mr_hold", mq_starve_hold, 0);
        chk("mr_instr", mq_wb_instruction, 0);
        chk("mr_lane0", mq_wb_result[31:0], 0);
        tick();
        reset = 1'b1;
        sc_wb_request = 1'b0;
        set_mx(1'b1, 32'h00000055);
        tick();
        set_mx(1'b0, 32'h0);
        chk("mr_byp_valid", mq_wb_valid, 1);
        chk("mr_byp_tag", mq_wb_instruction, 32'h55);
        chk("mr_byp_occ", mq_occupancy, 0);
        tick();
        chk("mr_byp_drop", mq_wb_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
